// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch stage for the multi-cycle core
//
// Holds the architectural PC and fetches one instruction at a time over a
// valid/ready request bus with an always-accepted response channel. The
// fetched word is handed to the IDU. The stage then waits for the next PC from
// the execute/write-back path before it fetches again, so only one instruction
// is ever in flight.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   mem_req_valid  fetch request valid (registered)
//   mem_req_ready  memory accepts the request
//   mem_req_addr   fetch address, always equal to pc
//   mem_rsp_valid  response valid; only consumed while waiting for one
//   mem_rsp_data   fetched instruction word
//   mem_rsp_err    bus error flag for this response
//   inst_valid     instruction to IDU valid (registered)
//   inst_ready     IDU accepts the instruction
//   inst           instruction word handed to the IDU
//   inst_pc        PC of inst
//   fetch_err      qualifies inst: misaligned PC or bus error
//   npc_valid      one-cycle pulse carrying the next PC
//   npc            next PC value (stored unmasked)
//   pc             current architectural PC
// -----------------------------------------------------------------------------
module ifu_fetch #(
    parameter int unsigned      WIDTH           = 32,
    parameter logic [WIDTH-1:0] RESET_PC        = 32'h8000_0000,
    // Enables the simulation-only bus protocol assertions.
    parameter bit               PROTOCOL_CHECKS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    input  logic             mem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_err,
    input  logic             npc_valid,
    input  logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // issue the bus request (or flag a misaligned PC)
        ST_WAIT = 2'd1,   // request accepted, waiting for the response
        ST_OUT  = 2'd2,   // instruction presented to the IDU
        ST_NPC  = 2'd3    // waiting for the next PC
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] inst_pc_reg;
    logic [31:0]      inst_reg;
    logic             fetch_err_reg;
    logic             req_valid_reg;
    logic             inst_valid_reg;
    logic             pc_misaligned;

    assign pc_misaligned = (pc_reg[1:0] != 2'b00);

    // Both handshake outputs are flops rather than state decodes, so reset
    // clears them at once and no input reaches them combinationally. After
    // reset the request therefore appears one cycle after release; when
    // arriving from ST_NPC the flag is preloaded so no bubble is inserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            inst_reg       <= 32'h0;
            inst_pc_reg    <= '0;
            fetch_err_reg  <= 1'b0;
            req_valid_reg  <= 1'b0;
            inst_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (pc_misaligned) begin
                        // Never put a misaligned address on the bus; report
                        // the fault to the IDU as a zero instruction instead.
                        inst_reg       <= 32'h0;
                        inst_pc_reg    <= pc_reg;
                        fetch_err_reg  <= 1'b1;
                        req_valid_reg  <= 1'b0;
                        inst_valid_reg <= 1'b1;
                        state_reg      <= ST_OUT;
                    end else if (req_valid_reg && mem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= ST_WAIT;
                    end else begin
                        req_valid_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        inst_reg       <= mem_rsp_data;
                        inst_pc_reg    <= pc_reg;
                        fetch_err_reg  <= mem_rsp_err;
                        inst_valid_reg <= 1'b1;
                        state_reg      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (inst_ready) begin
                        inst_valid_reg <= 1'b0;
                        state_reg      <= ST_NPC;
                    end
                end
                ST_NPC: begin
                    if (npc_valid) begin
                        pc_reg        <= npc;
                        req_valid_reg <= (npc[1:0] == 2'b00);
                        state_reg     <= ST_REQ;
                    end
                end
                default: begin
                    state_reg <= ST_REQ;
                end
            endcase
        end
    end

    assign mem_req_valid = req_valid_reg;
    assign mem_req_addr  = pc_reg;
    assign inst_valid    = inst_valid_reg;
    assign inst          = inst_reg;
    assign inst_pc       = inst_pc_reg;
    assign fetch_err     = fetch_err_reg;
    assign pc            = pc_reg;

    // Protocol checks: a next-PC pulse outside ST_NPC and a response outside
    // ST_WAIT are both dropped by the FSM, but they indicate a broken
    // neighbour, so flag them in simulation.
    generate
        if (PROTOCOL_CHECKS) begin : g_checks
            a_npc_only_in_npc: assert property (
                @(posedge clk) disable iff (!rst)
                npc_valid |-> (state_reg == ST_NPC));
            a_rsp_only_in_wait: assert property (
                @(posedge clk) disable iff (!rst)
                mem_rsp_valid |-> (state_reg == ST_WAIT));
            a_req_held: assert property (
                @(posedge clk) disable iff (!rst)
                (mem_req_valid && !mem_req_ready) |=>
                    (mem_req_valid && $stable(mem_req_addr)));
        end
    endgenerate

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch -- self-checking bench for ifu_fetch
//
// The bench plays both the memory and the IDU. Whenever it delivers a response
// (or steers the PC onto a misaligned address) it pushes the instruction it
// expects the IDU to see into a scoreboard queue; a negedge monitor pops and
// compares on every inst_valid & inst_ready handshake.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] pc;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_mis   = 0;
    int   req_cnt = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .WIDTH          (32),
        .RESET_PC       (RESET_PC),
        .PROTOCOL_CHECKS(1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .fetch_err    (fetch_err),
        .npc_valid    (npc_valid),
        .npc          (npc),
        .pc           (pc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Negedge monitor: counts accepted requests and scores IDU handshakes.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_req_valid && mem_req_ready) begin
            req_cnt++;
        end
        if (rst === 1'b1 && inst_valid && inst_ready) begin
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_eq("sb_inst", 64'(inst), 64'(mon_e.inst));
                check_eq("sb_inst_pc", 64'(inst_pc), 64'(mon_e.pc));
                check_eq("sb_fetch_err", 64'(fetch_err), 64'(mon_e.err));
            end
            $display("IDU accept: pc=0x%08h inst=0x%08h err=%0b", inst_pc, inst, fetch_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            cyc();
            n++;
        end
        check_eq("req_seen", 64'(mem_req_valid), 64'd1);
    endtask

    // IDU side: instruction is up now; hold it for out_dly cycles, then take it.
    task automatic present(input exp_t e, input int out_dly, input bit bad_npc);
        check_eq("inst_valid_up", 64'(inst_valid), 64'd1);
        for (int i = 0; i < out_dly; i++) begin
            if (bad_npc && i == 0) begin
                npc_valid = 1'b1;
                npc       = 32'h1234_5670;
            end
            cyc();
            npc_valid = 1'b0;
            check_eq("out_hold_valid", 64'(inst_valid), 64'd1);
            check_eq("out_hold_inst", 64'(inst), 64'(e.inst));
            check_eq("out_hold_pc", 64'(inst_pc), 64'(e.pc));
            check_eq("out_hold_err", 64'(fetch_err), 64'(e.err));
            check_eq("out_pc_unchanged", 64'(pc), 64'(e.pc));
        end
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        check_eq("inst_valid_down", 64'(inst_valid), 64'd0);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic advance_pc(input logic [31:0] next_pc);
        cyc();
        check_eq("npc_no_req", 64'(mem_req_valid), 64'd0);
        npc_valid = 1'b1;
        npc       = next_pc;
        cyc();
        npc_valid = 1'b0;
        check_eq("pc_loaded", 64'(pc), 64'(next_pc));
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input int rdy_dly, input int rsp_dly, input int out_dly,
                         input bit bad_npc, input logic [31:0] next_pc);
        int   base;
        exp_t e;
        wait_req();
        check_eq("req_addr", 64'(mem_req_addr), 64'(addr));
        check_eq("pc_in_req", 64'(pc), 64'(addr));
        base = req_cnt;
        for (int i = 0; i < rdy_dly; i++) begin
            cyc();
            check_eq("req_hold_valid", 64'(mem_req_valid), 64'd1);
            check_eq("req_hold_addr", 64'(mem_req_addr), 64'(addr));
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        check_eq("req_drop_after_hs", 64'(mem_req_valid), 64'd0);
        check_eq("req_count", 64'(req_cnt), 64'(base + 1));
        for (int i = 0; i < rsp_dly; i++) begin
            cyc();
            check_eq("no_inst_in_wait", 64'(inst_valid), 64'd0);
        end
        check_eq("no_inst_before_rsp", 64'(inst_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        e.inst = data;
        e.pc   = addr;
        e.err  = err;
        sb_q.push_back(e);
        $display("MEM rsp: addr=0x%08h data=0x%08h err=%0b", addr, data, err);
        cyc();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        present(e, out_dly, bad_npc);
        advance_pc(next_pc);
    endtask

    // pc was just loaded with a misaligned value: no bus traffic, error to IDU.
    task automatic fetch_misaligned(input logic [31:0] addr, input int out_dly,
                                    input logic [31:0] next_pc);
        int   base;
        exp_t e;
        base = req_cnt;
        check_eq("mis_no_req", 64'(mem_req_valid), 64'd0);
        e.inst = 32'h0;
        e.pc   = addr;
        e.err  = 1'b1;
        sb_q.push_back(e);
        cyc();
        check_eq("mis_no_req_out", 64'(mem_req_valid), 64'd0);
        present(e, out_dly, 1'b0);
        check_eq("mis_req_count", 64'(req_cnt), 64'(base));
        advance_pc(next_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        rst           = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        inst_ready    = 1'b0;
        npc_valid     = 1'b0;
        npc           = 32'h0;
        repeat (3) cyc();
        check_eq("rst_pc", 64'(pc), 64'(RESET_PC));
        check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_fetch_err", 64'(fetch_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic fetch with single-cycle latency.
        fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0004);
        // Memory stalls the request for three cycles.
        fetch(32'h8000_0004, 32'h0011_0113, 1'b0, 3, 1, 0, 1'b0, 32'h8000_0008);
        // IDU stalls four cycles; a stray next-PC pulse in OUT must be ignored.
        fetch(32'h8000_0008, 32'h0020_0193, 1'b0, 0, 0, 4, 1'b1, 32'h8000_0006);
        // Misaligned PC: error reported without any bus request.
        fetch_misaligned(32'h8000_0006, 1, 32'h8000_0010);
        // Bus error on the response; FSM still proceeds.
        fetch(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1, 2, 0, 1'b0, 32'h8000_0010);
        // Re-fetch of the same address is legal.
        fetch(32'h8000_0010, 32'h0030_0213, 1'b0, 0, 0, 1, 1'b0, 32'h8000_0014);

        // Reset while waiting for a response.
        wait_req();
        check_eq("pre_rst_addr", 64'(mem_req_addr), 64'h8000_0014);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("arst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("arst_inst", 64'(inst), 64'd0);
        check_eq("arst_inst_pc", 64'(inst_pc), 64'd0);
        check_eq("arst_fetch_err", 64'(fetch_err), 64'd0);
        check_eq("arst_pc", 64'(pc), 64'(RESET_PC));
        @(negedge clk);
        rst           = 1'b1;
        // Stale response from before the reset arrives before the new request.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        cyc();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        check_eq("stale_rsp_dropped", 64'(inst_valid), 64'd0);
        fetch(32'h8000_0000, 32'h0010_0073, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0100);

        // A few sequential fetches with random stalls.
        a = 32'h8000_0100;
        for (int i = 0; i < 4; i++) begin
            fetch(a, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'b0, a + 32'd4);
            a = a + 32'd4;
        end

        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
